// File: rtl/wb_master_ctrl.sv
// ---------------------------------------------------------------------------
// wb_master_ctrl
// Single-outstanding Wishbone classic master. Takes one command at a time
// over a valid/ready handshake, runs one Wishbone cycle, and returns the
// result over a valid/ready response channel. All outputs are registered.
//
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a bus cycle that
// sees no ack within TIMEOUT_CYCLES cycles (reported via rsp_err). Without
// the macro the bus cycle waits for ack indefinitely and rsp_err is 0.
//
// Ports:
//   wb_clk_i   in   clock, all state on posedge
//   wb_rst_i   in   asynchronous reset, active low
//   cmd_valid  in   command request
//   cmd_ready  out  high only while idle; accept on valid && ready
//   cmd_we     in   1 = write, 0 = read
//   cmd_adr    in   [31:0] address
//   cmd_dat    in   [31:0] write data
//   cmd_sel    in   [3:0]  byte selects
//   rsp_valid  out  response available
//   rsp_ready  in   response consumed on valid && ready
//   rsp_dat    out  [31:0] read data (0 for writes and timeouts)
//   rsp_err    out  bus cycle timed out
//   wbm_*_o    out  Wishbone master cyc/stb/we/sel/adr/dat
//   wbm_ack_i  in   Wishbone ack (ignored unless a bus cycle is open)
//   wbm_dat_i  in   [31:0] Wishbone read data
// ---------------------------------------------------------------------------
module wb_master_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_master_ctrl: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_t;

  state_t      r_state,     w_nxt_state;
  logic        r_cmd_ready, w_nxt_cmd_ready;
  logic        r_cyc,       w_nxt_cyc;
  logic        r_stb,       w_nxt_stb;
  logic        r_we,        w_nxt_we;
  logic [3:0]  r_sel,       w_nxt_sel;
  logic [31:0] r_adr,       w_nxt_adr;
  logic [31:0] r_dat,       w_nxt_dat;
  logic        r_rsp_valid, w_nxt_rsp_valid;
  logic [31:0] r_rsp_dat,   w_nxt_rsp_dat;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = TIMEOUT_CYCLES[15:0];

  logic        r_rsp_err,   w_nxt_rsp_err;
  logic [15:0] r_cnt,       w_nxt_cnt;
`endif

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cyc       = r_cyc;
    w_nxt_stb       = r_stb;
    w_nxt_we        = r_we;
    w_nxt_sel       = r_sel;
    w_nxt_adr       = r_adr;
    w_nxt_dat       = r_dat;
    w_nxt_rsp_valid = r_rsp_valid;
    w_nxt_rsp_dat   = r_rsp_dat;
`ifdef WB_MASTER_TIMEOUT_EN
    w_nxt_rsp_err   = r_rsp_err;
    w_nxt_cnt       = r_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        // r_cmd_ready (not just the state) gates acceptance so that the
        // first cycle after reset release never takes a command.
        if (cmd_valid && r_cmd_ready) begin
          w_nxt_state = ST_BUS;
          w_nxt_cyc   = 1'b1;
          w_nxt_stb   = 1'b1;
          w_nxt_we    = cmd_we;
          w_nxt_sel   = cmd_sel;
          w_nxt_adr   = cmd_adr;
          w_nxt_dat   = cmd_dat;
`ifdef WB_MASTER_TIMEOUT_EN
          w_nxt_cnt   = '0;
`endif
        end
      end

      ST_BUS: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (wbm_ack_i) begin
          w_nxt_state     = ST_RESP;
          w_nxt_cyc       = 1'b0;
          w_nxt_stb       = 1'b0;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_dat   = r_we ? '0 : wbm_dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
          w_nxt_rsp_err   = 1'b0;
        end else if (r_cnt == TO_LIMIT) begin
          w_nxt_state     = ST_RESP;
          w_nxt_cyc       = 1'b0;
          w_nxt_stb       = 1'b0;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_dat   = '0;
          w_nxt_rsp_err   = 1'b1;
        end else begin
          w_nxt_cnt       = r_cnt + 16'd1;
`endif
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_nxt_state     = ST_IDLE;
          w_nxt_rsp_valid = 1'b0;
          w_nxt_rsp_dat   = '0;
`ifdef WB_MASTER_TIMEOUT_EN
          w_nxt_rsp_err   = 1'b0;
`endif
        end
      end

      default: w_nxt_state = ST_IDLE;
    endcase

    // Registered ready tracks the next state, so the response handshake
    // cycle itself can never also accept a command.
    w_nxt_cmd_ready = (w_nxt_state == ST_IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
`endif
    end else begin
      r_state     <= w_nxt_state;
      r_cmd_ready <= w_nxt_cmd_ready;
      r_cyc       <= w_nxt_cyc;
      r_stb       <= w_nxt_stb;
      r_we        <= w_nxt_we;
      r_sel       <= w_nxt_sel;
      r_adr       <= w_nxt_adr;
      r_dat       <= w_nxt_dat;
      r_rsp_valid <= w_nxt_rsp_valid;
      r_rsp_dat   <= w_nxt_rsp_dat;
`ifdef WB_MASTER_TIMEOUT_EN
      r_rsp_err   <= w_nxt_rsp_err;
      r_cnt       <= w_nxt_cnt;
`endif
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
`ifdef WB_MASTER_TIMEOUT_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_master_ctrl
// Directed bench for wb_master_ctrl. Expected responses are queued when a
// command is issued and compared when the response handshake happens.
// Timeout scenarios are compiled in when WB_MASTER_TIMEOUT_EN is defined;
// otherwise the indefinite-wait behaviour is exercised instead.
// ---------------------------------------------------------------------------
module tb_wb_master_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  wb_master_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Values the open bus cycle must present
  logic        cur_we;
  logic [31:0] cur_adr;
  logic [31:0] cur_dat;
  logic [3:0]  cur_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each posedge.
  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check_bus(input string tag);
    check({tag, "_cyc"}, 32'(wbm_cyc_o), 32'd1);
    check({tag, "_stb"}, 32'(wbm_stb_o), 32'd1);
    check({tag, "_we"},  32'(wbm_we_o),  32'(cur_we));
    check({tag, "_adr"}, wbm_adr_o,      cur_adr);
    check({tag, "_dat"}, wbm_dat_o,      cur_dat);
    check({tag, "_sel"}, 32'(wbm_sel_o), 32'(cur_sel));
  endtask

  // Present a command, wait for acceptance, and queue the expected response.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_dat, input logic exp_err);
    int unsigned guard = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    while (!cmd_ready && guard < 20) begin
      step();
      guard++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cur_we  = we;
    cur_adr = adr;
    cur_dat = dat;
    cur_sel = sel;
    e.dat   = exp_dat;
    e.err   = exp_err;
    sb_q.push_back(e);
    step();
    // Garbage on the command bus must not disturb the open cycle
    cmd_valid = 1'b0;
    cmd_we    = ~we;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
    cmd_sel   = ~sel;
    check_bus("bus_start");
    check("busy_ready", 32'(cmd_ready), 32'd0);
  endtask

  // Hold the cycle open for n_wait cycles, then ack on the following one.
  task automatic ack_after(input int unsigned n_wait, input logic [31:0] ack_dat);
    for (int unsigned i = 0; i < n_wait; i++) begin
      step();
      check_bus("bus_hold");
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = ack_dat;
    step();
    wbm_ack_i = 1'b0;
    wbm_dat_i = $urandom;
    check("ack_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    check("ack_stb_drop", 32'(wbm_stb_o), 32'd0);
  endtask

  // Compare the response against the scoreboard, stall it for `hold` cycles,
  // then consume it and confirm the return to idle.
  task automatic collect(input int unsigned hold);
    int unsigned guard = 0;
    exp_t e;
    while (!rsp_valid && guard < 20) begin
      step();
      guard++;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'(sb_q.size()), 32'd1);
      e.dat = '0;
      e.err = 1'b0;
    end else begin
      e = sb_q.pop_front();
    end
    check("rsp_dat", rsp_dat, e.dat);
    check("rsp_err", 32'(rsp_err), 32'(e.err));
    rsp_ready = 1'b0;
    for (int unsigned i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_dat", rsp_dat, e.dat);
      check("hold_err", 32'(rsp_err), 32'(e.err));
      check("hold_ready", 32'(cmd_ready), 32'd0);
      check("hold_cyc", 32'(wbm_cyc_o), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_cyc", 32'(wbm_cyc_o), 32'd0);
    check("done_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wb_rst_i  = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    cur_we    = 1'b0;
    cur_adr   = '0;
    cur_dat   = '0;
    cur_sel   = '0;

    // Reset state
    #23;
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    wb_rst_i = 1'b1;
    step();
    check("rel_ready", 32'(cmd_ready), 32'd1);

    // Stray ack while idle
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h5A5A_5A5A;
    step();
    step();
    wbm_ack_i = 1'b0;
    check("stray_cyc", 32'(wbm_cyc_o), 32'd0);
    check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray_ready", 32'(cmd_ready), 32'd1);

    // Write, ack two cycles after strobe: cyc high for three cycles
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    ack_after(2, 32'hAAAA_5555);
    collect(0);

    // Read with a stalled response; the next command is held on the
    // command bus throughout the response phase.
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h1234_5678, 1'b0);
    ack_after(1, 32'h1234_5678);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0014;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h3;
    collect(5);
    check("b2b_gap_adr", wbm_adr_o, 32'h3000_0010);
    issue(1'b0, 32'h3000_0014, 32'h0, 4'h3, 32'hCAFE_F00D, 1'b0);
    ack_after(0, 32'hCAFE_F00D);
    collect(1);

`ifdef WB_MASTER_TIMEOUT_EN
    // No ack: strobe stays high five cycles, then an error response
    issue(1'b0, 32'h3000_0018, 32'h0, 4'hF, 32'h0, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check_bus("to_hold");
    end
    step();
    check("to_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    collect(1);

    // Ack on the same cycle the count reaches the limit wins
    issue(1'b0, 32'h3000_001C, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0);
    ack_after(4, 32'h0BAD_F00D);
    collect(0);
`else
    // Without the timeout the cycle stays open until ack arrives
    issue(1'b1, 32'h3000_0018, 32'h1111_2222, 4'hC, 32'h0, 1'b0);
    ack_after(20, 32'h7777_8888);
    collect(0);
`endif

    // Asynchronous reset in the middle of a bus cycle
    issue(1'b1, 32'h3000_0020, 32'h5555_AAAA, 4'h5, 32'h0, 1'b0);
    step();
    check_bus("mid_bus");
    #3;
    wb_rst_i = 1'b0;
    #1;
    check("arst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("arst_stb", 32'(wbm_stb_o), 32'd0);
    check("arst_we", 32'(wbm_we_o), 32'd0);
    check("arst_adr", wbm_adr_o, 32'd0);
    check("arst_dat", wbm_dat_o, 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    #2;
    wb_rst_i = 1'b1;
    step();
    check("arel_ready", 32'(cmd_ready), 32'd1);
    check("arel_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    check("arel_rsp_valid2", 32'(rsp_valid), 32'd0);

    // Normal operation after the aborted cycle
    issue(1'b0, 32'h3000_0024, 32'h0, 4'h1, 32'h0000_00A5, 1'b0);
    ack_after(1, 32'h0000_00A5);
    collect(2);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_master_ctrl.md
WB_MASTER_CTRL -- requirements
Module: wb_master_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait for ack before aborting (range 1..65535).
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic rises on its posedge.
REQ-003 SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr, input, 32 bits: target address.
REQ-008 SHALL have port cmd_dat, input, 32 bits: write data.
REQ-009 SHALL have port cmd_sel, input, 4 bits: byte selects.
REQ-010 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: response consumed when rsp_valid && rsp_ready.
REQ-012 SHALL have port rsp_dat, output, 32 bits: read data (0 for writes).
REQ-013 SHALL have port rsp_err, output, 1 bit: transaction timed out.
REQ-014 SHALL have Wishbone master outputs wbm_cyc_o (1), wbm_stb_o (1), wbm_we_o (1), wbm_sel_o (4), wbm_adr_o (32) and wbm_dat_o (32).
REQ-015 SHALL have Wishbone master inputs wbm_ack_i (1) and wbm_dat_i (32).

Function
REQ-016 SHALL implement an FSM with states IDLE, BUS and RESP; all outputs SHALL be registered.
REQ-017 cmd_ready SHALL be 1 only in IDLE.
REQ-018 On handshake in IDLE at cycle N: latch we/adr/dat/sel; at N+1 wbm_cyc_o = wbm_stb_o = 1 with the latched values driven; state goes to BUS.
REQ-019 In BUS, cyc/stb/adr/dat/sel/we SHALL be held stable until ack or timeout.
REQ-020 If wbm_ack_i = 1 in BUS at cycle M: at M+1 cyc = stb = 0, rsp_valid = 1, rsp_err = 0; rsp_dat = wbm_dat_i sampled at M for reads, 0 for writes; state goes to RESP.
REQ-021 In RESP, rsp_valid/rsp_dat/rsp_err SHALL be held until rsp_ready = 1; the cycle after that handshake, rsp_valid = 0 and state returns to IDLE.
REQ-022 A new command SHALL NOT be accepted in the same cycle as the response handshake (minimum 1 IDLE cycle between transactions).
REQ-023 wbm_ack_i SHALL be ignored outside BUS (stray ack has no effect).
REQ-024 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-025 Asserting wb_rst_i low SHALL immediately force IDLE, cmd_ready = 0, and cyc/stb/we/rsp_valid/rsp_err = 0, with sel/adr/dat/rsp_dat = 0.
REQ-026 In the first clock after wb_rst_i deasserts, cmd_ready SHALL go to 1.
REQ-027 Reset during BUS or RESP SHALL abort the transaction with no response produced.

Configuration
REQ-028 Macro WB_MASTER_TIMEOUT_EN SHALL control the timeout feature.
REQ-029 When WB_MASTER_TIMEOUT_EN is defined: a 16-bit counter SHALL clear on BUS entry and increment each BUS cycle without ack. When it reaches TIMEOUT_CYCLES, the next cycle SHALL give cyc = stb = 0, rsp_valid = 1, rsp_err = 1, rsp_dat = 0, and go to RESP.
REQ-030 Ack arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL win (rsp_err = 0).
REQ-031 When WB_MASTER_TIMEOUT_EN is not defined: no counter SHALL exist, BUS SHALL wait indefinitely, rsp_err SHALL be tied to 0, and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-032 Write: cmd adr = 0x3000_0004, dat = 0xDEAD_BEEF, sel = 0xF, we = 1; ack 2 cycles after stb -> cyc/stb high exactly 3 cycles with stable values, then rsp_valid = 1, rsp_err = 0, rsp_dat = 0.
REQ-033 Read: adr = 0x3000_0010, slave returns 0x1234_5678 with ack -> rsp_dat = 0x1234_5678; with rsp_ready held low 5 cycles, rsp is held stable and cmd_ready stays 0.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES = 4): no ack -> stb high 5 cycles, then rsp_err = 1, rsp_dat = 0; ack at count = 4 -> rsp_err = 0.
REQ-035 Reset mid-BUS: assert wb_rst_i low asynchronously between edges -> cyc/stb drop immediately, no rsp_valid; after release, cmd_ready = 1 on the next edge.
REQ-036 Stray ack in IDLE and cmd_valid during RESP -> no state change and no bus activity; back-to-back commands are separated by at least 1 IDLE cycle.
